// File: rtl/sram_ctrl_if.sv
// Request/response channel between a CPU memory stage and sram_ctrl.
// Handshake: a request transfers on a rising sck edge where req_valid && req_ready;
// rsp_valid is a one-cycle pulse per accepted request, in acceptance order.
interface sram_ctrl_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_ctrl.sv
// Registered asynchronous-SRAM controller: one access at a time, programmable
// read/write wait states, per-byte enables and a read-to-write turnaround guard.
module sram_ctrl #(
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 16,
   parameter int RD_WAIT  = 2,
   parameter int WR_WAIT  = 2,
   parameter int TURN_CYC = 1
) (
   input  logic                  sck,
   input  logic                  rst,
   sram_ctrl_if.slave            bus,
   output logic [ADDR_W-1:0]     sram_addr,
   inout  wire  [DATA_W-1:0]     sram_data,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic [DATA_W/8-1:0]   sram_be_n,
   output logic [2:0]            dbg_state
);
   localparam int BE_W  = DATA_W / 8;
   localparam int MAX_A = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
   localparam int MAX_C = (MAX_A > TURN_CYC) ? MAX_A : TURN_CYC;
   localparam int CW    = $clog2(MAX_C + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      TURN    = 3'd2,
      W_SETUP = 3'd3,
      W_PULSE = 3'd4,
      W_HOLD  = 3'd5
   } state_t;

   state_t              state, state_next;
   logic [CW-1:0]       cnt, cnt_next;
   logic                last_rd, last_rd_next;
   logic                ready_q;
   logic                accept, done;
   logic [BE_W-1:0]     be_q, be_sel;
   logic [DATA_W-1:0]   wdata_q;
   logic                drive_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                ce_next, oe_next, we_next, drive_next;
   logic [BE_W-1:0]     be_n_next;

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      last_rd_next = last_rd;
      done         = 1'b0;
      accept       = bus.req_valid && ready_q;
      be_sel       = accept ? bus.req_be : be_q;

      case (state)
         IDLE: begin
            if (accept) begin
               cnt_next = '0;
               if (!bus.req_we)
                  state_next = READ;
               else if (last_rd && (TURN_CYC > 0))
                  state_next = TURN;
               else
                  state_next = W_SETUP;
            end
         end
         READ: begin
            if (cnt == CW'(RD_WAIT - 1)) begin
               state_next   = IDLE;
               done         = 1'b1;
               last_rd_next = 1'b1;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         TURN: begin
            last_rd_next = 1'b0;
            if (cnt == CW'(TURN_CYC - 1)) begin
               state_next = W_SETUP;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         W_SETUP: begin
            state_next = W_PULSE;
            cnt_next   = '0;
         end
         W_PULSE: begin
            if (cnt == CW'(WR_WAIT - 1))
               state_next = W_HOLD;
            else
               cnt_next = cnt + CW'(1);
         end
         W_HOLD: begin
            state_next   = IDLE;
            done         = 1'b1;
            last_rd_next = 1'b0;
         end
         default: state_next = IDLE;
      endcase

      // Pin values are decoded from the state being entered, so every pin is a flop.
      ce_next    = 1'b1;
      oe_next    = 1'b1;
      we_next    = 1'b1;
      be_n_next  = '1;
      drive_next = 1'b0;
      case (state_next)
         READ: begin
            ce_next   = 1'b0;
            oe_next   = 1'b0;
            be_n_next = ~be_sel;
         end
         W_SETUP, W_HOLD: begin
            ce_next    = 1'b0;
            be_n_next  = ~be_sel;
            drive_next = 1'b1;
         end
         W_PULSE: begin
            ce_next    = 1'b0;
            we_next    = 1'b0;
            be_n_next  = ~be_sel;
            drive_next = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sck) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         last_rd     <= 1'b0;
         ready_q     <= 1'b0;
         be_q        <= '0;
         wdata_q     <= '0;
         sram_addr   <= '0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_be_n   <= '1;
         drive_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         last_rd   <= last_rd_next;
         ready_q   <= (state_next == IDLE);
         sram_ce_n <= ce_next;
         sram_oe_n <= oe_next;
         sram_we_n <= we_next;
         sram_be_n <= be_n_next;
         drive_q   <= drive_next;
         if (accept) begin
            sram_addr <= bus.req_addr;
            be_q      <= bus.req_be;
            wdata_q   <= bus.req_wdata;
         end
         rsp_valid_q <= done;
         // Read data is captured at the edge closing the last READ cycle.
         if (done)
            rsp_rdata_q <= (state == READ) ? sram_data : '0;
      end
   end

   assign sram_data     = drive_q ? wdata_q : {DATA_W{1'bz}};
   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign dbg_state     = state;
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: directed steps plus random request streams against a
// word-level memory model and a pin-level SRAM model.
module tb_sram_ctrl;
   localparam int ADDR_W   = 19;
   localparam int DATA_W   = 16;
   localparam int RD_WAIT  = 2;
   localparam int WR_WAIT  = 2;
   localparam int TURN_CYC = 1;

   typedef struct {
      bit          we;
      logic [18:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      int          gap;
   } req_t;

   logic          sck = 1'b0;
   logic          rst = 1'b1;
   logic [18:0]   sram_addr;
   wire  [15:0]   sram_data;
   logic          sram_ce_n, sram_oe_n, sram_we_n;
   logic [1:0]    sram_be_n;
   logic [2:0]    dbg_state;

   sram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sram_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT),
      .WR_WAIT(WR_WAIT), .TURN_CYC(TURN_CYC)
   ) dut (
      .sck(sck), .rst(rst), .bus(bus),
      .sram_addr(sram_addr), .sram_data(sram_data),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_be_n(sram_be_n), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 sck = ~sck;

   // pin-level SRAM model
   logic [15:0] sram_mem [int];
   logic [15:0] model_word = 16'h0;
   assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? model_word : 16'hzzzz;

   always @(negedge sck)
      model_word = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 16'h0;

   always @(posedge sck) begin
      if (!sram_ce_n && !sram_we_n) begin
         logic [15:0] w;
         w = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 16'h0;
         for (int l = 0; l < 2; l++)
            if (!sram_be_n[l]) w[8*l +: 8] = sram_data[8*l +: 8];
         sram_mem[int'(sram_addr)] = w;
      end
   end

   // reference model and scoreboard
   logic [15:0] ref_mem [int];
   logic [15:0] exp_q[$];
   int          lat_q[$];
   logic [1:0]  be_exp_q[$];
   logic [18:0] addr_exp_q[$];
   longint      ta_q[$];
   longint      tn_q[$];
   int          lat_obs[$];
   bit          prev_read = 1'b0;
   int exp_oe, exp_we, exp_drv, exp_gap;
   int total = 0;
   int bad = 0;

   // pin monitor
   int oe_cnt, we_cnt, drv_cnt, gap_cnt, viol, be_err, addr_err, rsp_seen;
   int inflight = 0;

   always @(negedge sck) begin
      if (!rst) begin
         if (!sram_ce_n && !sram_oe_n) oe_cnt++;
         if (!sram_ce_n && !sram_we_n) we_cnt++;
         if (sram_oe_n && sram_data !== 16'hzzzz) drv_cnt++;
         if (sram_ce_n && sram_data !== 16'hzzzz) viol++;
         if (!sram_oe_n && !sram_we_n) viol++;
         if (!sram_oe_n && $isunknown(sram_data)) viol++;
         if (inflight > 0 && sram_ce_n && !bus.rsp_valid) gap_cnt++;
         if (!sram_ce_n && be_exp_q.size() > 0 && sram_be_n !== ~be_exp_q[0]) be_err++;
         if (!sram_ce_n && addr_exp_q.size() > 0 && sram_addr !== addr_exp_q[0]) addr_err++;
         if (bus.rsp_valid) rsp_seen++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_rd(input logic [18:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0;
   endfunction

   function automatic void preload(input logic [18:0] a, input logic [15:0] v);
      sram_mem[int'(a)] = v;
      ref_mem[int'(a)]  = v;
   endfunction

   function automatic void model_push(input req_t r);
      logic [15:0] w;
      bit turn;
      if (r.we) begin
         turn = prev_read && (TURN_CYC > 0);
         lat_q.push_back(WR_WAIT + 3 + (turn ? TURN_CYC : 0));
         if (turn) exp_gap += TURN_CYC;
         w = ref_rd(r.addr);
         if (r.be[0]) w[7:0]  = r.wdata[7:0];
         if (r.be[1]) w[15:8] = r.wdata[15:8];
         ref_mem[int'(r.addr)] = w;
         exp_q.push_back(16'h0);
         exp_we  += WR_WAIT;
         exp_drv += WR_WAIT + 2;
         prev_read = 1'b0;
      end else begin
         lat_q.push_back(RD_WAIT + 1);
         exp_q.push_back(ref_rd(r.addr));
         exp_oe += RD_WAIT;
         prev_read = 1'b1;
      end
      be_exp_q.push_back(r.be);
      addr_exp_q.push_back(r.addr);
   endfunction

   // driver tasks
   task automatic reset_dut();
      @(negedge sck);
      bus.req_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge sck);
      rst = 1'b0;
      prev_read = 1'b0;
      @(negedge sck);
   endtask

   task automatic run_plan(input string tag, input req_t plan[$]);
      int n;
      n = plan.size();
      oe_cnt = 0; we_cnt = 0; drv_cnt = 0; gap_cnt = 0;
      viol = 0; be_err = 0; addr_err = 0; rsp_seen = 0;
      exp_oe = 0; exp_we = 0; exp_drv = 0; exp_gap = 0;
      ta_q.delete(); tn_q.delete(); lat_obs.delete();
      fork
         begin
            for (int i = 0; i < n; i++) begin
               int w;
               @(negedge sck);
               if (plan[i].gap > 0) begin
                  bus.req_valid = 1'b0;
                  repeat (plan[i].gap) @(negedge sck);
               end
               bus.req_valid = 1'b1;
               bus.req_we    = plan[i].we;
               bus.req_addr  = plan[i].addr;
               bus.req_wdata = plan[i].wdata;
               bus.req_be    = plan[i].be;
               model_push(plan[i]);
               w = 0;
               while (!bus.req_ready && w < 100) begin
                  @(negedge sck);
                  w++;
               end
               if (w >= 100) check({tag, "_accept_timeout"}, 0, 1);
               @(posedge sck);
               ta_q.push_back($time);
               inflight++;
            end
            @(negedge sck);
            bus.req_valid = 1'b0;
            bus.req_wdata = 16'($urandom);
         end
         begin
            for (int i = 0; i < n; i++) begin
               int w;
               int lat;
               w = 0;
               @(negedge sck);
               while (!bus.rsp_valid && w < 200) begin
                  @(negedge sck);
                  w++;
               end
               if (w >= 200) begin
                  check({tag, "_rsp_timeout"}, 0, 1);
                  lat = -1;
               end else begin
                  tn_q.push_back($time);
                  inflight--;
                  lat = int'(($time - ta_q[i] - 5) / 10) + 1;
                  check({tag, "_rdata"}, bus.rsp_rdata, exp_q[0]);
                  check({tag, "_latency"}, lat, lat_q[0]);
               end
               lat_obs.push_back(lat);
               void'(exp_q.pop_front());
               void'(lat_q.pop_front());
               void'(be_exp_q.pop_front());
               void'(addr_exp_q.pop_front());
            end
         end
      join
      @(negedge sck);
      check({tag, "_rsp_count"}, rsp_seen, n);
      check({tag, "_oe_cycles"}, oe_cnt, exp_oe);
      check({tag, "_we_cycles"}, we_cnt, exp_we);
      check({tag, "_drive_cycles"}, drv_cnt, exp_drv);
      check({tag, "_turn_cycles"}, gap_cnt, exp_gap);
      check({tag, "_bus_viol"}, viol, 0);
      check({tag, "_be_lanes"}, be_err, 0);
      check({tag, "_addr"}, addr_err, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired: observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      req_t p[$];
      req_t r;
      int rsp_before;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;

      // reset state
      repeat (3) @(negedge sck);
      check("rst_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      check("rst_addr", sram_addr, 0);
      check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
      check("rst_be_n", sram_be_n, 2'b11);
      check("rst_bus_z", sram_data === 16'hzzzz, 1);
      rst = 1'b0;
      @(negedge sck);
      check("post_rst_ready", bus.req_ready, 1);

      // plain read
      preload(19'h00010, 16'h1234);
      p.delete();
      r = '{we: 1'b0, addr: 19'h00010, wdata: 16'h0, be: 2'b11, gap: 0}; p.push_back(r);
      run_plan("t1", p);
      check("t1_lat_abs", lat_obs[0], 3);

      // full write at the top address, then readback
      reset_dut();
      p.delete();
      r = '{we: 1'b1, addr: 19'h7FFFF, wdata: 16'hBEEF, be: 2'b11, gap: 0}; p.push_back(r);
      r = '{we: 1'b0, addr: 19'h7FFFF, wdata: 16'h0,    be: 2'b11, gap: 2}; p.push_back(r);
      run_plan("t2", p);
      check("t2_wr_lat_abs", lat_obs[0], 5);

      // byte-lane write and an all-lanes-off write
      preload(19'h00020, 16'hAAAA);
      p.delete();
      r = '{we: 1'b1, addr: 19'h00020, wdata: 16'h5555, be: 2'b01, gap: 0}; p.push_back(r);
      r = '{we: 1'b0, addr: 19'h00020, wdata: 16'h0,    be: 2'b11, gap: 1}; p.push_back(r);
      r = '{we: 1'b1, addr: 19'h00020, wdata: 16'hFFFF, be: 2'b00, gap: 1}; p.push_back(r);
      r = '{we: 1'b0, addr: 19'h00020, wdata: 16'h0,    be: 2'b11, gap: 1}; p.push_back(r);
      run_plan("t3", p);
      check("t3_mem_word", sram_mem[32'h20], 16'hAA55);

      // read immediately followed by a write
      reset_dut();
      p.delete();
      r = '{we: 1'b0, addr: 19'h00020, wdata: 16'h0,    be: 2'b11, gap: 0}; p.push_back(r);
      r = '{we: 1'b1, addr: 19'h00030, wdata: 16'hC0DE, be: 2'b11, gap: 0}; p.push_back(r);
      run_plan("t4", p);
      check("t4_wr_lat_abs", lat_obs[1], WR_WAIT + 3 + TURN_CYC);

      // back-to-back reads
      preload(19'h00001, 16'h1111);
      preload(19'h00002, 16'h2222);
      p.delete();
      r = '{we: 1'b0, addr: 19'h00001, wdata: 16'h0, be: 2'b11, gap: 0}; p.push_back(r);
      r = '{we: 1'b0, addr: 19'h00002, wdata: 16'h0, be: 2'b11, gap: 0}; p.push_back(r);
      run_plan("t5", p);
      check("t5_accept_on_rsp", int'(ta_q[1] - tn_q[0]), 5);

      // reset during the write pulse
      reset_dut();
      preload(19'h00040, 16'h2468);
      @(negedge sck);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 19'h00040;
      bus.req_wdata = 16'h1357;
      bus.req_be    = 2'b11;
      for (int w = 0; w < 100 && !bus.req_ready; w++) @(negedge sck);
      check("t6_ready_before", bus.req_ready, 1);
      @(posedge sck);
      @(negedge sck);
      bus.req_valid = 1'b0;
      @(negedge sck);
      check("t6_in_pulse", sram_we_n, 0);
      rsp_before = rsp_seen;
      rst = 1'b1;
      @(negedge sck);
      check("t6_we_n", sram_we_n, 1);
      check("t6_ce_n", sram_ce_n, 1);
      check("t6_bus_z", sram_data === 16'hzzzz, 1);
      check("t6_rsp_valid", bus.rsp_valid, 0);
      check("t6_ready_in_rst", bus.req_ready, 0);
      @(negedge sck);
      rst = 1'b0;
      prev_read = 1'b0;
      @(negedge sck);
      check("t6_ready_after", bus.req_ready, 1);
      check("t6_no_rsp", rsp_seen, rsp_before);
      // the pulse edge before reset wrote the whole word
      ref_mem[32'h40] = 16'h1357;
      p.delete();
      r = '{we: 1'b0, addr: 19'h00040, wdata: 16'h0, be: 2'b11, gap: 0}; p.push_back(r);
      run_plan("t6", p);

      // random streams
      for (int b = 0; b < 4; b++) begin
         p.delete();
         for (int i = 0; i < 12; i++) begin
            r.we    = 1'($urandom_range(0, 1));
            r.addr  = 19'($urandom_range(0, 15)) | ((b % 2 == 1) ? 19'h7FFF0 : 19'h0);
            r.wdata = 16'($urandom);
            r.be    = r.we ? 2'($urandom_range(0, 3)) : 2'b11;
            r.gap   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            p.push_back(r);
         end
         run_plan("rnd", p);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
